// File: rtl/punc_run_ctrl.sv
// Run/halt/step controller with breakpoint comparators for a small core.
// Define PUNC_INSTR_COUNT_EN to build the retired-instruction counter.
module punc_run_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int NUM_BP   = 4,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_idx,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              instr_done,
  input  logic              trap_halt,
  output logic              core_en,
  output logic [1:0]        run_state,
  output logic [1:0]        stop_cause,
  output logic [2:0]        bp_hit_idx,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    DRAINING = 2'd3
  } state_e;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;

  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_TRAP = 2'd3;

  localparam state_e RESET_ST = AUTO_RUN ? RUNNING : HALTED;

  state_e              state_q, state_d;
  logic                core_en_q;
  logic [1:0]          cause_q, cause_d;
  logic [2:0]          hit_q, hit_d;
  logic [NUM_BP-1:0]   bp_en_q;
  logic [ADDR_W-1:0]   bp_addr_q [NUM_BP];
  logic                accept;
  logic                bp_match;
  logic [2:0]          bp_idx;

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are both high.
  assign cmd_ready  = (state_q == HALTED) || (state_q == RUNNING);
  assign accept     = cmd_valid && cmd_ready;
  assign core_en    = core_en_q;
  assign run_state  = state_q;
  assign stop_cause = cause_q;
  assign bp_hit_idx = hit_q;

  // Downward scan so the lowest matching index wins.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc_next)) begin
        bp_match = 1'b1;
        bp_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hit_d   = hit_q;
    unique case (state_q)
      HALTED: begin
        if (accept && cmd_op == OP_RUN)       state_d = RUNNING;
        else if (accept && cmd_op == OP_STEP) state_d = STEPPING;
      end
      RUNNING: begin
        if (instr_done && trap_halt) begin
          state_d = HALTED;
          cause_d = CAUSE_TRAP;
        end else if (instr_done && bp_match) begin
          state_d = HALTED;
          cause_d = CAUSE_BP;
          hit_d   = bp_idx;
        end else if (accept && cmd_op == OP_HALT) begin
          if (instr_done) begin
            state_d = HALTED;
            cause_d = CAUSE_CMD;
          end else begin
            state_d = DRAINING;
          end
        end
      end
      STEPPING, DRAINING: begin
        if (instr_done) begin
          state_d = HALTED;
          cause_d = trap_halt ? CAUSE_TRAP : CAUSE_CMD;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_ST;
      core_en_q <= (RESET_ST != HALTED);
      cause_q   <= 2'd0;
      hit_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      core_en_q <= (state_d != HALTED);
      cause_q   <= cause_d;
      hit_q     <= hit_d;
    end
  end

  // Out-of-range indices match no slot, so such writes are accepted and dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else if (accept && (cmd_op == OP_SET_BP || cmd_op == OP_CLR_BP)) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (int'(cmd_idx) == i) begin
          if (cmd_op == OP_SET_BP) begin
            bp_en_q[i]   <= 1'b1;
            bp_addr_q[i] <= cmd_addr;
          end else begin
            bp_en_q[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PUNC_INSTR_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept && cmd_op == OP_RUN && state_q == HALTED) begin
      cnt_q <= '0;
    end else if (instr_done && core_en_q) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_punc_run_ctrl.sv
// Directed bench for punc_run_ctrl; covers step, breakpoints, drain, trap priority and reset.
module tb_punc_run_ctrl;

`ifdef PUNC_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_idx;
  logic [15:0] cmd_addr;
  logic [15:0] pc_next;
  logic        instr_done;
  logic        trap_halt;
  logic        core_en;
  logic [1:0]  run_state;
  logic [1:0]  stop_cause;
  logic [2:0]  bp_hit_idx;
  logic [31:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;

  punc_run_ctrl #(.ADDR_W(16), .NUM_BP(4), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_addr(cmd_addr),
    .pc_next(pc_next), .instr_done(instr_done), .trap_halt(trap_halt),
    .core_en(core_en), .run_state(run_state), .stop_cause(stop_cause),
    .bp_hit_idx(bp_hit_idx), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ec(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Present one command for a single cycle.
  task automatic cmd(input logic [2:0] op, input logic [2:0] idx, input logic [15:0] addr);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_addr = addr;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  // Retire one instruction for a single cycle.
  task automatic retire(input logic [15:0] pc, input logic trap);
    instr_done = 1'b1; pc_next = pc; trap_halt = trap;
    tick();
    instr_done = 1'b0; trap_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_idx = 3'd0; cmd_addr = 16'h0;
    pc_next = 16'h0; instr_done = 1'b0; trap_halt = 1'b0;
    tick(); tick();
    chk("rst_state", run_state, 2'd0);
    chk("rst_core_en", core_en, 1'b0);
    chk("rst_cause", stop_cause, 2'd0);
    chk("rst_hit", bp_hit_idx, 3'd0);
    chk("rst_count", instr_count, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1'b1);

    // Single step
    cmd(3'd3, 3'd0, 16'h0);
    chk("step_state", run_state, 2'd2);
    chk("step_core_en", core_en, 1'b1);
    chk("step_ready", cmd_ready, 1'b0);
    retire(16'h3001, 1'b0);
    chk("step_done_state", run_state, 2'd0);
    chk("step_done_core_en", core_en, 1'b0);
    chk("step_done_cause", stop_cause, 2'd1);
    chk("step_count", instr_count, ec(1));

    // Breakpoint stop on the fifth retire, then resume past it
    cmd(3'd4, 3'd2, 16'h3005);
    cmd(3'd1, 3'd0, 16'h0);
    chk("run_state", run_state, 2'd1);
    chk("run_count_clr", instr_count, 32'd0);
    for (int k = 1; k <= 4; k++) retire(16'(16'h3000 + k), 1'b0);
    chk("bp_pre_state", run_state, 2'd1);
    retire(16'h3005, 1'b0);
    chk("bp_state", run_state, 2'd0);
    chk("bp_cause", stop_cause, 2'd2);
    chk("bp_hit", bp_hit_idx, 3'd2);
    chk("bp_count", instr_count, ec(5));
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h3006, 1'b0);
    chk("resume_state", run_state, 2'd1);
    chk("resume_count", instr_count, ec(1));

    // HALT with no retire -> drain until the next retire
    cmd(3'd2, 3'd0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      chk("drain_state", run_state, 2'd3);
      chk("drain_ready", cmd_ready, 1'b0);
      chk("drain_core_en", core_en, 1'b1);
      tick();
    end
    retire(16'h3007, 1'b0);
    chk("drain_done_state", run_state, 2'd0);
    chk("drain_done_cause", stop_cause, 2'd1);
    chk("drain_hit_held", bp_hit_idx, 3'd2);

    // HALT together with a retire stops directly
    cmd(3'd1, 3'd0, 16'h0);
    cmd_valid = 1'b1; cmd_op = 3'd2; instr_done = 1'b1; pc_next = 16'h1000;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; instr_done = 1'b0;
    chk("halt_direct_state", run_state, 2'd0);
    chk("halt_direct_cause", stop_cause, 2'd1);
    chk("halt_direct_count", instr_count, ec(1));

    // Trap beats breakpoint
    cmd(3'd4, 3'd0, 16'h3002);
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h3002, 1'b1);
    chk("trap_state", run_state, 2'd0);
    chk("trap_cause", stop_cause, 2'd3);
    chk("trap_hit_held", bp_hit_idx, 3'd2);

    // Lowest matching index wins; clearing it exposes the next one
    cmd(3'd4, 3'd1, 16'h3005);
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h3005, 1'b0);
    chk("low_idx_cause", stop_cause, 2'd2);
    chk("low_idx_hit", bp_hit_idx, 3'd1);
    cmd(3'd5, 3'd1, 16'h0);
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h3005, 1'b0);
    chk("clr_idx_state", run_state, 2'd0);
    chk("clr_idx_hit", bp_hit_idx, 3'd2);

    // Breakpoint write in the same cycle as a matching retire uses the old value
    cmd(3'd1, 3'd0, 16'h0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_idx = 3'd3; cmd_addr = 16'h4000;
    instr_done = 1'b1; pc_next = 16'h4000;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; instr_done = 1'b0;
    chk("same_cycle_state", run_state, 2'd1);
    retire(16'h4000, 1'b0);
    chk("new_bp_state", run_state, 2'd0);
    chk("new_bp_hit", bp_hit_idx, 3'd3);

    // Out-of-range breakpoint index is accepted and ignored
    chk("idx7_ready", cmd_ready, 1'b1);
    cmd(3'd4, 3'd7, 16'h5000);
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h5000, 1'b0);
    chk("idx7_no_bp", run_state, 2'd1);
    chk("idx7_count", instr_count, ec(1));

`ifdef PUNC_INSTR_COUNT_EN
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    retire(16'h5001, 1'b0);
    chk("count_wrap", instr_count, 32'd0);
`endif

    // Trap while stepping
    retire(16'h5002, 1'b1);
    chk("run_trap_cause", stop_cause, 2'd3);
    cmd(3'd3, 3'd0, 16'h0);
    retire(16'h5003, 1'b1);
    chk("step_trap_state", run_state, 2'd0);
    chk("step_trap_cause", stop_cause, 2'd3);

    // Asynchronous reset while stepping
    cmd(3'd3, 3'd0, 16'h0);
    chk("pre_rst_state", run_state, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_state", run_state, 2'd0);
    chk("async_rst_core_en", core_en, 1'b0);
    chk("async_rst_cause", stop_cause, 2'd0);
    chk("async_rst_hit", bp_hit_idx, 3'd0);
    chk("async_rst_count", instr_count, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1'b1);
    retire(16'h3005, 1'b0);
    chk("post_rst_no_pending", run_state, 2'd0);
    cmd(3'd1, 3'd0, 16'h0);
    retire(16'h3005, 1'b0);
    retire(16'h4000, 1'b0);
    chk("post_rst_bp_cleared", run_state, 2'd1);
    chk("post_rst_count", instr_count, ec(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
